// File: rtl/ens0_pkg.sv
// Shared types and defaults for the ens0 input front end.
package ens0_pkg;

    // Packer control states: collecting pixels, or holding a completed frame
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

    localparam int unsigned DEF_PIX_W   = 8;
    localparam int unsigned DEF_IN_BW   = 1;
    localparam int unsigned DEF_NUM_PIX = 784;

    localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/ens0_vec_reg.sv
// Output stage register between the input packer and layer 0.
// Holds one vector under a valid/ready handshake; a load may coincide with a drain.
module ens0_vec_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_free,
    output logic              o_xfer
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_xfer  = r_valid && i_ready;
    // A vector being drained this cycle frees the slot for a same-cycle load
    assign o_free  = !r_valid || i_ready;

    // Load replaces the held vector; otherwise a drain empties the register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ens0_input_packer.sv
// Serial pixel packer feeding ens0 layer 0: quantises each pixel by MSB truncation
// and packs NUM_PIX of them into one flat vector, double-buffered behind ens0_vec_reg.
// Optional framing check on s_pix_last: define ENS0_PACK_LAST_CHECK_EN.
module ens0_input_packer
    import ens0_pkg::*;
#(
    parameter int unsigned PIX_W   = DEF_PIX_W,
    parameter int unsigned IN_BW   = DEF_IN_BW,
    parameter int unsigned NUM_PIX = DEF_NUM_PIX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         s_pix_data,
    input  logic                     s_pix_valid,
    output logic                     s_pix_ready,
    input  logic                     s_pix_last,
    output logic [NUM_PIX*IN_BW-1:0] m_vec_data,
    output logic                     m_vec_valid,
    input  logic                     m_vec_ready,
    output logic [FRAME_CNT_W-1:0]   frame_count,
    output logic                     frame_err
);

    localparam int unsigned VEC_W = NUM_PIX * IN_BW;
    localparam int unsigned IDX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);

    pack_state_e             r_state;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_ready;
    logic [VEC_W-1:0]        r_fill;
    logic [FRAME_CNT_W-1:0]  r_frame_count;

    logic [IN_BW-1:0]        w_q;
    logic [VEC_W-1:0]        w_fill_nxt;
    int unsigned             w_base;
    logic                    w_accept;
    logic                    w_at_last;
    logic                    w_abort;
    logic                    w_bad_end;
    logic                    w_free;
    logic                    w_xfer;
    logic                    w_load;
    logic [VEC_W-1:0]        w_load_data;
    logic                    w_unused;

    // Low pixel bits are dropped by quantisation; s_pix_last only matters with the check
    assign w_unused = ^{s_pix_data, s_pix_last};

    assign w_q         = s_pix_data[PIX_W-1 -: IN_BW];
    assign w_accept    = s_pix_valid && r_ready;
    assign w_at_last   = (r_idx == LAST_IDX);
    assign s_pix_ready = r_ready;

`ifdef ENS0_PACK_LAST_CHECK_EN
    assign w_abort   = w_accept && s_pix_last && !w_at_last;
    assign w_bad_end = w_accept && w_at_last && !s_pix_last;
`else
    assign w_abort   = 1'b0;
    assign w_bad_end = 1'b0;
`endif

    // Fill buffer with the current pixel merged into its slot
    always_comb begin
        w_base     = 32'(r_idx) * IN_BW;
        w_fill_nxt = r_fill;
        w_fill_nxt[w_base +: IN_BW] = w_q;
    end

    // Hand a frame to the output register: on completion in FILL, or released from HOLD
    always_comb begin
        w_load      = 1'b0;
        w_load_data = w_fill_nxt;
        unique case (r_state)
            FILL: w_load = w_accept && w_at_last && w_free;
            HOLD: begin
                w_load      = w_free;
                w_load_data = r_fill;
            end
        endcase
    end

    // Packer FSM: slot index, fill buffer and registered pixel ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_fill  <= '0;
        end else begin
            unique case (r_state)
                FILL: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_fill <= w_fill_nxt;
                        if (w_abort) begin
                            r_idx <= '0;
                        end else if (w_at_last) begin
                            r_idx <= '0;
                            if (!w_free) begin
                                r_state <= HOLD;
                                r_ready <= 1'b0;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_free) begin
                        r_state <= FILL;
                        r_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Count vectors accepted downstream; wraps naturally at the counter width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (w_xfer) begin
            r_frame_count <= r_frame_count + 1'b1;
        end
    end

    assign frame_count = r_frame_count;

`ifdef ENS0_PACK_LAST_CHECK_EN
    logic r_err;

    // Sticky framing error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_abort || w_bad_end) begin
            r_err <= 1'b1;
        end
    end

    assign frame_err = r_err;
`else
    assign frame_err = 1'b0;
`endif

    ens0_vec_reg #(
        .DATA_W (VEC_W)
    ) u_vec_reg (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .o_data  (m_vec_data),
        .o_valid (m_vec_valid),
        .i_ready (m_vec_ready),
        .o_free  (w_free),
        .o_xfer  (w_xfer)
    );

endmodule

// File: tb/tb_ens0_input_packer.sv
// Self-checking bench for ens0_input_packer: a small instance (NUM_PIX=4, IN_BW=2)
// and a default instance (NUM_PIX=784, IN_BW=1) driven from one clock.
module tb_ens0_input_packer;

    localparam int unsigned S_NP = 4;
    localparam int unsigned S_BW = 2;
    localparam int unsigned D_NP = 784;
    localparam int unsigned D_BW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Small instance
    logic [7:0]           sp_data = '0;
    logic                 sp_valid = 1'b0;
    logic                 sp_last = 1'b0;
    logic                 sp_ready;
    logic [S_NP*S_BW-1:0] sv_data;
    logic                 sv_valid;
    logic                 sv_ready = 1'b0;
    logic [15:0]          s_cnt;
    logic                 s_err;

    // Default instance
    logic [7:0]           dp_data = '0;
    logic                 dp_valid = 1'b0;
    logic                 dp_last = 1'b0;
    logic                 dp_ready;
    logic [D_NP*D_BW-1:0] dv_data;
    logic                 dv_valid;
    logic                 dv_ready = 1'b0;
    logic [15:0]          d_cnt;
    logic                 d_err;

    int n_asserts = 0;
    int n_fail    = 0;

    ens0_input_packer #(
        .PIX_W   (8),
        .IN_BW   (S_BW),
        .NUM_PIX (S_NP)
    ) u_dut_s (
        .clk         (clk),
        .rst         (rst),
        .s_pix_data  (sp_data),
        .s_pix_valid (sp_valid),
        .s_pix_ready (sp_ready),
        .s_pix_last  (sp_last),
        .m_vec_data  (sv_data),
        .m_vec_valid (sv_valid),
        .m_vec_ready (sv_ready),
        .frame_count (s_cnt),
        .frame_err   (s_err)
    );

    ens0_input_packer u_dut_d (
        .clk         (clk),
        .rst         (rst),
        .s_pix_data  (dp_data),
        .s_pix_valid (dp_valid),
        .s_pix_ready (dp_ready),
        .s_pix_last  (dp_last),
        .m_vec_data  (dv_data),
        .m_vec_valid (dv_valid),
        .m_vec_ready (dv_ready),
        .frame_count (d_cnt),
        .frame_err   (d_err)
    );

    // Reference packing: keep the top S_BW bits of each pixel, pixel i at bits [i*S_BW +: S_BW]
    function automatic logic [S_NP*S_BW-1:0] pack_s(input logic [S_NP-1:0][7:0] p);
        logic [S_NP*S_BW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(S_NP); i++) begin
            v[i*S_BW +: S_BW] = S_BW'(p[i] >> (8 - S_BW));
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sp_valid = 1'b0; sp_last = 1'b0; sv_ready = 1'b0;
        dp_valid = 1'b0; dp_last = 1'b0; dv_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_asserts++; if (sp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", sp_ready); end
        n_asserts++; if (sv_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", sv_valid); end
        n_asserts++; if (sv_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 00", sv_data); end
        n_asserts++; if (s_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", s_cnt); end
        n_asserts++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", s_err); end
        n_asserts++; if (dv_valid !== 1'b0 || dp_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_default got valid=%b ready=%b want 0 0", dv_valid, dp_ready);
        end
        tick();
        n_asserts++; if (sp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_held_ready got %b want 0", sp_ready); end
        rst = 1'b0;
        #1;
        n_asserts++; if (sp_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early got %b want 0", sp_ready); end
        tick();
        n_asserts++; if (sp_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", sp_ready); end
    endtask

    task automatic test_example();
        logic [7:0] px [4];
        px[0] = 8'hC0; px[1] = 8'h40; px[2] = 8'hFF; px[3] = 8'h00;
        do_reset();
        sv_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sp_data = px[i]; sp_valid = 1'b1; sp_last = (i == 3);
            tick();
            if (i < 3) begin
                n_asserts++; if (sv_valid !== 1'b0) begin n_fail++; $display("FAIL example_early_valid px=%0d got %b want 0", i, sv_valid); end
            end
        end
        sp_valid = 1'b0; sp_last = 1'b0;
        n_asserts++; if (sv_valid !== 1'b1) begin n_fail++; $display("FAIL example_valid got %b want 1", sv_valid); end
        n_asserts++; if (sv_data !== 8'b00_11_01_11) begin n_fail++; $display("FAIL example_data got %b want 00110111", sv_data); end
        tick();
        n_asserts++; if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL example_count got %0d want 1", s_cnt); end
        n_asserts++; if (sv_valid !== 1'b0) begin n_fail++; $display("FAIL example_drain got %b want 0", sv_valid); end
    endtask

    task automatic test_back_to_back();
        logic [S_NP-1:0][7:0] fa;
        logic [S_NP-1:0][7:0] fb;
        for (int i = 0; i < int'(S_NP); i++) begin
            fa[i] = 8'($urandom);
            fb[i] = 8'($urandom);
        end
        do_reset();
        sv_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sp_data = (i < 4) ? fa[i] : fb[i-4];
            sp_valid = 1'b1; sp_last = ((i % 4) == 3);
            n_asserts++; if (sp_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_fill px=%0d got %b want 1", i, sp_ready); end
            tick();
        end
        n_asserts++; if (sp_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b want 0", sp_ready); end
        for (int i = 0; i < 3; i++) begin
            sp_data = 8'($urandom);
            tick();
            n_asserts++; if (sv_valid !== 1'b1 || sv_data !== pack_s(fa)) begin
                n_fail++; $display("FAIL b2b_hold got valid=%b data=%h want 1 %h", sv_valid, sv_data, pack_s(fa));
            end
            n_asserts++; if (sp_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_hold got %b want 0", sp_ready); end
        end
        sp_valid = 1'b0; sp_last = 1'b0;
        sv_ready = 1'b1;
        tick();
        n_asserts++; if (sv_valid !== 1'b1 || sv_data !== pack_s(fb)) begin
            n_fail++; $display("FAIL b2b_second got valid=%b data=%h want 1 %h", sv_valid, sv_data, pack_s(fb));
        end
        n_asserts++; if (sp_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_resume got %b want 1", sp_ready); end
        n_asserts++; if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL b2b_count1 got %0d want 1", s_cnt); end
        tick();
        n_asserts++; if (sv_valid !== 1'b0 || s_cnt !== 16'd2) begin
            n_fail++; $display("FAIL b2b_drain got valid=%b count=%0d want 0 2", sv_valid, s_cnt);
        end
        sv_ready = 1'b0;
    endtask

    // Random traffic against a frame-level model: completed frames awaiting transfer
    task automatic test_random_stream();
        logic [S_NP*S_BW-1:0] expq [$];
        logic [S_NP-1:0][7:0] pix;
        int   n = 0;
        int   cnt = 0;
        logic acc;
        logic xfer;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            sp_valid = ($urandom_range(0, 3) != 0);
            sp_data  = 8'($urandom);
            sp_last  = (n == int'(S_NP) - 1);
            sv_ready = ($urandom_range(0, 2) == 0);
            n_asserts++; if (sp_ready !== (expq.size() < 2)) begin
                n_fail++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, sp_ready, expq.size() < 2);
            end
            n_asserts++; if (sv_valid !== (expq.size() >= 1)) begin
                n_fail++; $display("FAIL rand_valid cyc=%0d got %b want %b", cyc, sv_valid, expq.size() >= 1);
            end
            if (expq.size() >= 1) begin
                n_asserts++; if (sv_data !== expq[0]) begin
                    n_fail++; $display("FAIL rand_data cyc=%0d got %h want %h", cyc, sv_data, expq[0]);
                end
            end
            n_asserts++; if (s_cnt !== 16'(cnt)) begin
                n_fail++; $display("FAIL rand_count cyc=%0d got %0d want %0d", cyc, s_cnt, cnt);
            end
            acc  = sp_valid && (expq.size() < 2);
            xfer = sv_ready && (expq.size() >= 1);
            tick();
            if (xfer) begin
                void'(expq.pop_front());
                cnt++;
            end
            if (acc) begin
                pix[n] = sp_data;
                n++;
                if (n == int'(S_NP)) begin
                    expq.push_back(pack_s(pix));
                    n = 0;
                end
            end
        end
        sp_valid = 1'b0; sp_last = 1'b0; sv_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [S_NP-1:0][7:0] pix;
        do_reset();
        sv_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sp_data = 8'hFF; sp_valid = 1'b1; sp_last = (i == 3);
            tick();
        end
        sp_valid = 1'b0; sp_last = 1'b0;
        n_asserts++; if (sv_valid !== 1'b1 || sv_data !== 8'hFF) begin
            n_fail++; $display("FAIL midrst_pre got valid=%b data=%h want 1 ff", sv_valid, sv_data);
        end
        #2;
        rst = 1'b1;
        #1;
        n_asserts++; if (sv_valid !== 1'b0 || sv_data !== 8'h00) begin
            n_fail++; $display("FAIL midrst_async got valid=%b data=%h want 0 00", sv_valid, sv_data);
        end
        n_asserts++; if (sp_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b want 0", sp_ready); end
        tick();
        rst = 1'b0;
        tick();
        sv_ready = 1'b1;
        for (int i = 0; i < int'(S_NP); i++) begin
            pix[i] = 8'($urandom);
            sp_data = pix[i]; sp_valid = 1'b1; sp_last = (i == int'(S_NP) - 1);
            tick();
        end
        sp_valid = 1'b0; sp_last = 1'b0;
        n_asserts++; if (sv_valid !== 1'b1 || sv_data !== pack_s(pix)) begin
            n_fail++; $display("FAIL midrst_clean got valid=%b data=%h want 1 %h", sv_valid, sv_data, pack_s(pix));
        end
        tick();
        n_asserts++; if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_count got %0d want 1", s_cnt); end
        sv_ready = 1'b0;
    endtask

    task automatic test_default_stream();
        logic [D_NP*D_BW-1:0] exp_v;
        logic [7:0]           px;
        int                   slot;
        do_reset();
        dv_ready = 1'b1;
        exp_v = '0;
        for (int i = 0; i < 3 * int'(D_NP); i++) begin
            slot = i % int'(D_NP);
            px = 8'($urandom);
            exp_v[slot*D_BW +: D_BW] = D_BW'(px >> (8 - D_BW));
            dp_data = px; dp_valid = 1'b1; dp_last = (slot == int'(D_NP) - 1);
            n_asserts++; if (dp_ready !== 1'b1) begin n_fail++; $display("FAIL dflt_stall px=%0d got %b want 1", i, dp_ready); end
            tick();
            n_asserts++; if (dv_valid !== (slot == int'(D_NP) - 1)) begin
                n_fail++; $display("FAIL dflt_valid px=%0d got %b want %b", i, dv_valid, slot == int'(D_NP) - 1);
            end
            if (slot == int'(D_NP) - 1) begin
                n_asserts++; if (dv_data !== exp_v) begin n_fail++; $display("FAIL dflt_data frame=%0d differs", i / int'(D_NP)); end
            end
        end
        dp_valid = 1'b0; dp_last = 1'b0;
        tick();
        n_asserts++; if (d_cnt !== 16'd3) begin n_fail++; $display("FAIL dflt_count got %0d want 3", d_cnt); end
        n_asserts++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL dflt_err got %b want 0", d_err); end
        dv_ready = 1'b0;
    endtask

    // Misplaced s_pix_last on the 2nd pixel, then a correctly framed frame
    task automatic test_last_check();
        logic [S_NP-1:0][7:0] pix;
        do_reset();
        sv_ready = 1'b1;
        pix[0] = 8'($urandom);
        pix[1] = 8'($urandom);
        sp_valid = 1'b1;
        sp_data = pix[0]; sp_last = 1'b0; tick();
        sp_data = pix[1]; sp_last = 1'b1; tick();
`ifdef ENS0_PACK_LAST_CHECK_EN
        n_asserts++; if (s_err !== 1'b1) begin n_fail++; $display("FAIL last_err_set got %b want 1", s_err); end
        for (int i = 0; i < int'(S_NP); i++) begin
            pix[i] = 8'($urandom);
            sp_data = pix[i]; sp_last = (i == int'(S_NP) - 1);
            n_asserts++; if (sv_valid !== 1'b0) begin n_fail++; $display("FAIL last_no_vec px=%0d got %b want 0", i, sv_valid); end
            tick();
        end
        n_asserts++; if (s_err !== 1'b1) begin n_fail++; $display("FAIL last_err_sticky got %b want 1", s_err); end
`else
        for (int i = 2; i < int'(S_NP); i++) begin
            pix[i] = 8'($urandom);
            sp_data = pix[i]; sp_last = 1'b0;
            n_asserts++; if (sv_valid !== 1'b0) begin n_fail++; $display("FAIL last_ignored_early px=%0d got %b want 0", i, sv_valid); end
            tick();
        end
        n_asserts++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL last_err_tied got %b want 0", s_err); end
`endif
        sp_valid = 1'b0; sp_last = 1'b0;
        n_asserts++; if (sv_valid !== 1'b1 || sv_data !== pack_s(pix)) begin
            n_fail++; $display("FAIL last_vec got valid=%b data=%h want 1 %h", sv_valid, sv_data, pack_s(pix));
        end
        tick();
        n_asserts++; if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL last_count got %0d want 1", s_cnt); end
        sv_ready = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_example();
        test_back_to_back();
        test_random_stream();
        test_mid_reset();
        test_default_stream();
        test_last_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
